// File: rtl/sqrt_iter_hs.sv
// Iterative restoring integer square root, ITER_PER_CYCLE root bits per clock; SQRT_REM_EN exposes out_rem.
// Latency: IN_W/(2*ITER_PER_CYCLE) clocks from accept to out_valid.
// Backpressure: result held while out_ready=0; a new radicand is accepted in the cycle the result is taken.
module sqrt_iter_hs #(
   parameter int IN_W           = 32,
   parameter int ITER_PER_CYCLE = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IN_W-1:0]   in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IN_W/2-1:0] out_root,
   output logic              out_exact
`ifdef SQRT_REM_EN
   ,
   output logic [IN_W/2:0]   out_rem
`endif
);

   localparam int H     = IN_W / 2;
   localparam int RW    = H + 2;
   localparam int STEPS = H / ITER_PER_CYCLE;
   localparam int CNT_W = $clog2(STEPS + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state_q,     state_d;
   logic [IN_W-1:0]   rad_q,       rad_d;
   logic [RW-1:0]     rem_q,       rem_d;
   logic [H-1:0]      root_q,      root_d;
   logic [CNT_W-1:0]  cnt_q,       cnt_d;
   logic              out_valid_q, out_valid_d;
   logic [H-1:0]      out_root_q,  out_root_d;
   logic              out_exact_q, out_exact_d;
`ifdef SQRT_REM_EN
   logic [H:0]        out_rem_q,   out_rem_d;
`endif

   logic [IN_W-1:0]   rad_v;
   logic [RW-1:0]     rem_v, rem_t, trial;
   logic [H-1:0]      root_v;
   logic              accept;

   assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = out_valid_q;
   assign out_root  = out_root_q;
   assign out_exact = out_exact_q;
`ifdef SQRT_REM_EN
   assign out_rem   = out_rem_q;
`endif

   // Unrolled restoring steps; rem never exceeds 2*root so RW bits always suffice.
   always_comb begin
      rad_v  = rad_q;
      rem_v  = rem_q;
      root_v = root_q;
      rem_t  = '0;
      trial  = '0;
      for (int i = 0; i < ITER_PER_CYCLE; i++) begin
         rem_t = {rem_v[RW-3:0], rad_v[IN_W-1 -: 2]};
         trial = {root_v, 2'b01};
         rad_v = {rad_v[IN_W-3:0], 2'b00};
         if (rem_t >= trial) begin
            rem_v  = rem_t - trial;
            root_v = {root_v[H-2:0], 1'b1};
         end else begin
            rem_v  = rem_t;
            root_v = {root_v[H-2:0], 1'b0};
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rad_d       = rad_q;
      rem_d       = rem_q;
      root_d      = root_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_root_d  = out_root_q;
      out_exact_d = out_exact_q;
`ifdef SQRT_REM_EN
      out_rem_d   = out_rem_q;
`endif
      case (state_q)
         CALC: begin
            rad_d  = rad_v;
            rem_d  = rem_v;
            root_d = root_v;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
               out_root_d  = root_v;
               out_exact_d = (rem_v == '0);
`ifdef SQRT_REM_EN
               out_rem_d   = rem_v[H:0];
`endif
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         end
         IDLE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Accept overrides the DONE->IDLE move, giving back-to-back operation.
      if (accept) begin
         state_d = CALC;
         rad_d   = in_data;
         rem_d   = '0;
         root_d  = '0;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rad_q       <= '0;
         rem_q       <= '0;
         root_q      <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_root_q  <= '0;
         out_exact_q <= 1'b0;
`ifdef SQRT_REM_EN
         out_rem_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         rad_q       <= rad_d;
         rem_q       <= rem_d;
         root_q      <= root_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_root_q  <= out_root_d;
         out_exact_q <= out_exact_d;
`ifdef SQRT_REM_EN
         out_rem_q   <= out_rem_d;
`endif
      end
   end

endmodule
